// File: rtl/frame_stats_if.sv
// Pixel stream in, per-frame statistics record out, grouped for frame_stats.
// The slave modport is the statistics block; the master modport is the upstream source and the stats consumer.
interface frame_stats_if #(
    parameter int FRAME_WIDTH  = 128,
    parameter int FRAME_HEIGHT = 128
);
    localparam int TOTAL_PIXELS = FRAME_WIDTH * FRAME_HEIGHT;
    localparam int SUM_W        = $clog2(TOTAL_PIXELS) + 8;
    localparam int CNT_W        = $clog2(TOTAL_PIXELS + 1);

    logic             pix_valid;
    logic [7:0]       gray;
    logic             binary;
    logic             frame_sync;
    logic             stats_ready;
    logic             stats_valid;
    logic [15:0]      frame_idx;
    logic [7:0]       gray_min;
    logic [7:0]       gray_max;
    logic [SUM_W-1:0] gray_sum;
    logic [CNT_W-1:0] bin_count;
    logic             overrun;

    modport master (
        output pix_valid, gray, binary, frame_sync, stats_ready,
        input  stats_valid, frame_idx, gray_min, gray_max, gray_sum, bin_count, overrun
    );

    modport slave (
        input  pix_valid, gray, binary, frame_sync, stats_ready,
        output stats_valid, frame_idx, gray_min, gray_max, gray_sum, bin_count, overrun
    );
endinterface

// File: rtl/frame_stats.sv
// Per-frame gray min/max/sum and binary ones count over a raster pixel stream.
// Latency: record valid one cycle after the last pixel of a frame; no input gap between frames.
// Backpressure: never stalls pixels; an unread record is overwritten and the sticky overrun flag is set.
module frame_stats #(
    parameter int FRAME_WIDTH  = 128,
    parameter int FRAME_HEIGHT = 128
) (
    input  logic           clk,
    input  logic           rst_n,
    frame_stats_if.slave   st
);
    localparam int TOTAL_PIXELS = FRAME_WIDTH * FRAME_HEIGHT;
    localparam int SUM_W        = $clog2(TOTAL_PIXELS) + 8;
    localparam int CNT_W        = $clog2(TOTAL_PIXELS + 1);
    localparam int XW           = (FRAME_WIDTH  > 1) ? $clog2(FRAME_WIDTH)  : 1;
    localparam int YW           = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(FRAME_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(FRAME_HEIGHT - 1);

    typedef enum logic {EMPTY, FULL} state_t;

    typedef struct packed {
        logic [15:0]      idx;
        logic [7:0]       mn;
        logic [7:0]       mx;
        logic [SUM_W-1:0] sum;
        logic [CNT_W-1:0] cnt;
    } rec_t;

    state_t           state, state_nxt;
    rec_t             rec_q;
    logic             overrun_q;
    logic [15:0]      frame_cnt;
    logic [XW-1:0]    x, base_x, nxt_x;
    logic [YW-1:0]    y, base_y, nxt_y;
    logic [7:0]       acc_min, base_min, nxt_min;
    logic [7:0]       acc_max, base_max, nxt_max;
    logic [SUM_W-1:0] acc_sum, base_sum, nxt_sum;
    logic [CNT_W-1:0] acc_ones, base_ones, nxt_ones;
    logic             frame_end;

    // frame_sync restarts from init values, so a pixel in the same cycle lands at (0,0)
    always_comb begin
        base_x    = st.frame_sync ? '0    : x;
        base_y    = st.frame_sync ? '0    : y;
        base_min  = st.frame_sync ? 8'hFF : acc_min;
        base_max  = st.frame_sync ? 8'h00 : acc_max;
        base_sum  = st.frame_sync ? '0    : acc_sum;
        base_ones = st.frame_sync ? '0    : acc_ones;
        nxt_x     = base_x;
        nxt_y     = base_y;
        nxt_min   = base_min;
        nxt_max   = base_max;
        nxt_sum   = base_sum;
        nxt_ones  = base_ones;
        frame_end = 1'b0;
        if (st.pix_valid) begin
            if (st.gray < base_min) nxt_min = st.gray;
            if (st.gray > base_max) nxt_max = st.gray;
            nxt_sum   = base_sum + SUM_W'(st.gray);
            nxt_ones  = base_ones + CNT_W'(st.binary);
            frame_end = (base_x == X_LAST) && (base_y == Y_LAST);
            if (base_x == X_LAST) begin
                nxt_x = '0;
                nxt_y = (base_y == Y_LAST) ? '0 : base_y + YW'(1);
            end else begin
                nxt_x = base_x + XW'(1);
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        st.stats_valid = (state == FULL);
        case (state)
            EMPTY: if (frame_end) state_nxt = FULL;
            FULL:  if (!frame_end && st.stats_ready) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= EMPTY;
            rec_q     <= '0;
            overrun_q <= 1'b0;
            frame_cnt <= '0;
            x         <= '0;
            y         <= '0;
            acc_min   <= 8'hFF;
            acc_max   <= 8'h00;
            acc_sum   <= '0;
            acc_ones  <= '0;
        end else begin
            state <= state_nxt;
            x     <= nxt_x;
            y     <= nxt_y;
            if (frame_end) begin
                rec_q     <= '{idx: frame_cnt, mn: nxt_min, mx: nxt_max, sum: nxt_sum, cnt: nxt_ones};
                frame_cnt <= frame_cnt + 16'd1;
                acc_min   <= 8'hFF;
                acc_max   <= 8'h00;
                acc_sum   <= '0;
                acc_ones  <= '0;
                if (state == FULL && !st.stats_ready) overrun_q <= 1'b1;
            end else begin
                acc_min  <= nxt_min;
                acc_max  <= nxt_max;
                acc_sum  <= nxt_sum;
                acc_ones <= nxt_ones;
            end
        end
    end

    assign st.frame_idx = rec_q.idx;
    assign st.gray_min  = rec_q.mn;
    assign st.gray_max  = rec_q.mx;
    assign st.gray_sum  = rec_q.sum;
    assign st.bin_count = rec_q.cnt;
    assign st.overrun   = overrun_q;
endmodule

// File: tb/tb_frame_stats.sv
// Self-checking bench for frame_stats with a 4x2 frame and a record scoreboard.
// Records are queued as frames are driven and popped on each stats handshake.
module tb_frame_stats;
    localparam int W = 4;
    localparam int H = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    frame_stats_if #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H)) bus ();

    frame_stats #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .st    (bus)
    );

    typedef struct {
        int idx;
        int mn;
        int mx;
        int sum;
        int cnt;
    } rec_t;

    rec_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    int   m_x, m_y, m_min, m_max, m_sum, m_ones, m_fcnt;
    bit   m_full, m_ovr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_clear_acc();
        m_x = 0; m_y = 0; m_min = 255; m_max = 0; m_sum = 0; m_ones = 0;
    endtask

    // One clock: drive inputs, compare at the falling edge, advance the model, return just after the rising edge.
    task automatic step(input bit rn, input bit pv, input int g, input bit b, input bit fs, input bit rdy);
        bit   consumed;
        rec_t r;
        rst_n          = rn;
        bus.pix_valid  = pv;
        bus.gray       = 8'(g);
        bus.binary     = b;
        bus.frame_sync = fs;
        bus.stats_ready = rdy;
        @(negedge clk);
        check("stats_valid", 32'(bus.stats_valid), 32'(m_full));
        if (rn && bus.stats_valid && bus.stats_ready) begin
            check("sb_pending", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                r = sb_q.pop_front();
                check("sb_frame_idx", 32'(bus.frame_idx), r.idx);
                check("sb_gray_min",  32'(bus.gray_min),  r.mn);
                check("sb_gray_max",  32'(bus.gray_max),  r.mx);
                check("sb_gray_sum",  32'(bus.gray_sum),  r.sum);
                check("sb_bin_count", 32'(bus.bin_count), r.cnt);
                check("sb_overrun",   32'(bus.overrun),   32'(m_ovr));
            end
        end
        if (!rn) begin
            model_clear_acc();
            m_fcnt = 0; m_full = 0; m_ovr = 0;
            sb_q.delete();
        end else begin
            consumed = m_full && rdy;
            if (fs) model_clear_acc();
            if (pv) begin
                if (g < m_min) m_min = g;
                if (g > m_max) m_max = g;
                m_sum  += g;
                m_ones += int'(b);
                if (m_x == W-1 && m_y == H-1) begin
                    r = '{idx: m_fcnt, mn: m_min, mx: m_max, sum: m_sum, cnt: m_ones};
                    if (m_full && !rdy) begin
                        void'(sb_q.pop_back());
                        m_ovr = 1;
                    end
                    sb_q.push_back(r);
                    m_full = 1;
                    consumed = 0;
                    m_fcnt = (m_fcnt + 1) & 16'hFFFF;
                    model_clear_acc();
                end else if (m_x == W-1) begin
                    m_x = 0;
                    m_y++;
                end else begin
                    m_x++;
                end
            end
            if (consumed) m_full = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic px(input int g, input bit b, input bit rdy);
        step(1'b1, 1'b1, g, b, 1'b0, rdy);
    endtask

    task automatic idle(input bit rdy);
        step(1'b1, 1'b0, 0, 1'b0, 1'b0, rdy);
    endtask

    task automatic check_rec(input string tag, input int v, input int idx, input int mn, input int mx,
                             input int sum, input int cnt, input int ovr);
        check({tag, "_valid"},     32'(bus.stats_valid), v);
        check({tag, "_frame_idx"}, 32'(bus.frame_idx),   idx);
        check({tag, "_gray_min"},  32'(bus.gray_min),    mn);
        check({tag, "_gray_max"},  32'(bus.gray_max),    mx);
        check({tag, "_gray_sum"},  32'(bus.gray_sum),    sum);
        check({tag, "_bin_count"}, 32'(bus.bin_count),   cnt);
        check({tag, "_overrun"},   32'(bus.overrun),     ovr);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 77, 1'b1, 1'b0, 1'b1);
        check_rec("reset", 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.pix_valid = 1'b0; bus.gray = '0; bus.binary = 1'b0;
        bus.frame_sync = 1'b0; bus.stats_ready = 1'b0;
        model_clear_acc();
        m_fcnt = 0; m_full = 0; m_ovr = 0;
        @(posedge clk);
        #1;

        // basic frame, record visible for exactly one cycle
        do_reset();
        for (int i = 0; i < 8; i++) px(10 * (i + 1), (i % 2) == 0, 1'b1);
        check_rec("basic", 1, 0, 10, 80, 360, 4, 0);
        idle(1'b1);
        check("basic_one_cycle", 32'(bus.stats_valid), 32'd0);

        // backpressure: frame 0 overwritten by frame 1
        do_reset();
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 8; i++) px(f ? 200 : 5, f == 1, 1'b0);
        check_rec("backpress", 1, 1, 200, 200, 1600, 8, 1);
        idle(1'b1);

        // frame end coincides with the read of the previous record
        do_reset();
        for (int i = 0; i < 8; i++) px(i + 1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) px(50 + i, 1'b1, i == 7);
        check_rec("simul", 1, 1, 50, 57, 428, 8, 0);
        idle(1'b1);

        // abort with a pixel in the sync cycle
        do_reset();
        for (int i = 0; i < 3; i++) px(255, 1'b1, 1'b1);
        step(1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) px(1, 1'b0, 1'b1);
        check_rec("abort", 1, 0, 0, 1, 7, 0, 0);
        idle(1'b1);

        // gapped input
        do_reset();
        for (int i = 0; i < 8; i++) begin
            int gap;
            gap = (i == 0) ? 1 : int'($urandom_range(0, 2));
            for (int k = 0; k < gap; k++) idle(1'b1);
            px(10 * (i + 1), (i % 2) == 0, 1'b1);
        end
        check_rec("gapped", 1, 0, 10, 80, 360, 4, 0);
        idle(1'b1);

        // reset mid-frame discards the partial frame
        do_reset();
        for (int i = 0; i < 5; i++) px(99, 1'b1, 1'b1);
        do_reset();
        for (int i = 0; i < 8; i++) begin
            px(10 * (i + 1), (i % 2) == 0, 1'b1);
            if (i == 2) check("rstmid_no_record", 32'(bus.stats_valid), 32'd0);
        end
        check_rec("rstmid", 1, 0, 10, 80, 360, 4, 0);
        idle(1'b1);
        idle(1'b1);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
